// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel prescaled timer.
package multi_timer_pkg;

  // Channel FSM encoding, kept as plain 2-bit constants so legacy code can
  // compare against raw values.
  typedef logic [1:0] ch_state_t;

  localparam ch_state_t ST_IDLE = 2'd0;
  localparam ch_state_t ST_RUN  = 2'd1;
  localparam ch_state_t ST_DONE = 2'd2;

  // Channel mode as latched at start.
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/multi_timer_if.sv
// Register-block side of the multi-channel timer: controls in, status out.
interface multi_timer_if #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 16
);

  logic                      glb_en;
  logic [PRESC_W-1:0]        presc_div;
  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         stop;
  logic [NUM_CH-1:0]         mode;
  logic [NUM_CH*WIDTH-1:0]   cmp_val;
  logic [NUM_CH-1:0]         irq_mask;
  logic [NUM_CH-1:0]         irq_clr;

  logic [NUM_CH*WIDTH-1:0]   count;
  logic [NUM_CH-1:0]         running;
  logic [NUM_CH-1:0]         irq_pend;
  logic                      irq;

  // Register block / CPU side.
  modport master (
    output glb_en, presc_div, start, stop, mode, cmp_val, irq_mask, irq_clr,
    input  count, running, irq_pend, irq
  );

  // Timer side.
  modport slave (
    input  glb_en, presc_div, start, stop, mode, cmp_val, irq_mask, irq_clr,
    output count, running, irq_pend, irq
  );

endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: up-counter against a latched compare value with
// one-shot / periodic behaviour and a sticky expiry flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | stopped, count held at its last value
//   ST_RUN  | counting prescaler ticks towards cmp_q
//   ST_DONE | one-shot expired, count parked at cmp_q until start/stop
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clr_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             pend_o
);

  ch_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q,   cmp_d;
  logic             mode_q,  mode_d;
  logic             pend_q,  pend_d;

  // One bit wider than the counter so a compare value of all-ones is
  // reachable without the increment wrapping back to zero.
  logic [WIDTH:0]   nxt;
  logic             expire;

  assign nxt = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

  // Next-state logic: stop beats start, start beats a same-cycle tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    mode_d  = mode_q;
    expire  = 1'b0;

    if (stop_i) begin
      state_d = ST_IDLE;
    end else if (start_i) begin
      state_d = ST_RUN;
      count_d = '0;
      cmp_d   = cmp_val_i;
      mode_d  = mode_i;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_i) begin
            if (nxt >= {1'b0, cmp_q}) begin
              expire = 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                count_d = cmp_q;
                state_d = ST_DONE;
              end else begin
                count_d = '0;
                cmp_d   = cmp_val_i;
              end
            end else begin
              count_d = nxt[WIDTH-1:0];
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // An expiry landing on the same edge as a clear must not be lost.
    if (expire) begin
      pend_d = 1'b1;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      cmp_q   <= '0;
      mode_q  <= MODE_PERIODIC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign running_o = (state_q == ST_RUN);
  assign pend_o    = pend_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: shared programmable prescaler, NUM_CH independent
// channels and a registered, masked interrupt line.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  multi_timer_if.slave  bus
);

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    tick;
  logic                    irq_q, irq_d;

  logic [NUM_CH*WIDTH-1:0] count_w;
  logic [NUM_CH-1:0]       running_w;
  logic [NUM_CH-1:0]       pend_w;

  // Tick when the prescaler hits the divider; a divider lowered below the
  // current prescaler value is treated as an immediate match so it wraps.
  always_comb begin
    tick    = bus.glb_en && (presc_q >= bus.presc_div);
    presc_d = presc_q;
    if (!bus.glb_en) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .start_i   (bus.start[i]),
      .stop_i    (bus.stop[i]),
      .clr_i     (bus.irq_clr[i]),
      .mode_i    (bus.mode[i]),
      .cmp_val_i (bus.cmp_val[i*WIDTH +: WIDTH]),
      .count_o   (count_w[i*WIDTH +: WIDTH]),
      .running_o (running_w[i]),
      .pend_o    (pend_w[i])
    );
  end

  // Interrupt combine from registered pending bits only, so irq is glitch-free.
  always_comb begin
    irq_d = |(pend_w & bus.irq_mask);
  end

  // Interrupt output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.count    = count_w;
  assign bus.running  = running_w;
  assign bus.irq_pend = pend_w;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus a randomized
// run checked every cycle against a behavioural model.
module tb_multi_timer;

  localparam int NC = 4;
  localparam int W  = 8;
  localparam int PW = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_timer_if #(.NUM_CH(NC), .WIDTH(W), .PRESC_W(PW)) bus ();

  multi_timer #(.NUM_CH(NC), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model state.
  int m_presc;
  int m_st   [NC];
  int m_cnt  [NC];
  int m_cmp  [NC];
  bit m_os   [NC];
  bit m_pend [NC];
  bit m_irq;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [NC*W-1:0] exp_count();
    logic [NC*W-1:0] r;
    for (int i = 0; i < NC; i++) r[i*W +: W] = m_cnt[i][W-1:0];
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_running();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (m_st[i] == M_RUN);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_pend();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = m_pend[i];
    return r;
  endfunction

  // Advance model and DUT by one clock; pulse inputs are dropped afterwards.
  task automatic step();
    bit tick;
    bit any;
    bit ex;
    int cv;
    if (rst) begin
      m_presc = 0;
      m_irq   = 0;
      for (int i = 0; i < NC; i++) begin
        m_st[i] = M_IDLE; m_cnt[i] = 0; m_cmp[i] = 0; m_os[i] = 0; m_pend[i] = 0;
      end
    end else begin
      tick = bus.glb_en && (m_presc >= int'(bus.presc_div));
      if (!bus.glb_en || tick) m_presc = 0;
      else m_presc = m_presc + 1;
      any = 0;
      for (int i = 0; i < NC; i++) if (m_pend[i] && bus.irq_mask[i]) any = 1;
      m_irq = any;
      for (int i = 0; i < NC; i++) begin
        cv = int'(bus.cmp_val[i*W +: W]);
        ex = 0;
        if (bus.stop[i]) begin
          m_st[i] = M_IDLE;
        end else if (bus.start[i]) begin
          m_st[i] = M_RUN; m_cnt[i] = 0; m_cmp[i] = cv; m_os[i] = bus.mode[i];
        end else if (m_st[i] == M_RUN && tick) begin
          if (m_cnt[i] + 1 >= m_cmp[i]) begin
            ex = 1;
            if (m_os[i]) begin
              m_cnt[i] = m_cmp[i]; m_st[i] = M_DONE;
            end else begin
              m_cnt[i] = 0; m_cmp[i] = cv;
            end
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (ex) m_pend[i] = 1;
        else if (bus.irq_clr[i]) m_pend[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    bus.start   = '0;
    bus.stop    = '0;
    bus.irq_clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.glb_en = 1'b1;
    bus.start  = 4'b1111;
    repeat (3) step();
    n_checks++; if (bus.count !== '0) $display("FAIL reset_count got %h exp 0", bus.count); else n_pass++;
    n_checks++; if (bus.running !== '0) $display("FAIL reset_running got %b exp 0", bus.running); else n_pass++;
    n_checks++; if (bus.irq_pend !== '0) $display("FAIL reset_pend got %b exp 0", bus.irq_pend); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", bus.irq); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_periodic();
    bit exp_p, exp_i, prev_p;
    bus.glb_en = 1'b1;
    bus.presc_div = '0;
    bus.cmp_val[0*W +: W] = 8'd5;
    bus.mode[0] = 1'b0;
    bus.irq_mask = 4'b0001;
    bus.start[0] = 1'b1;
    step();
    n_checks++; if (bus.count[0*W +: W] !== 8'd0 || bus.running[0] !== 1'b1)
      $display("FAIL per_start got cnt %0d run %b exp 0 1", bus.count[0*W +: W], bus.running[0]); else n_pass++;
    prev_p = 0;
    for (int j = 1; j <= 12; j++) begin
      if (j == 6) bus.irq_clr[0] = 1'b1;
      step();
      exp_p = (j == 5) || (j >= 10);
      exp_i = prev_p;
      n_checks++; if (bus.count[0*W +: W] !== W'(j % 5))
        $display("FAIL per_count j=%0d got %0d exp %0d", j, bus.count[0*W +: W], j % 5); else n_pass++;
      n_checks++; if (bus.irq_pend[0] !== exp_p)
        $display("FAIL per_pend j=%0d got %b exp %b", j, bus.irq_pend[0], exp_p); else n_pass++;
      n_checks++; if (bus.irq !== exp_i)
        $display("FAIL per_irq j=%0d got %b exp %b", j, bus.irq, exp_i); else n_pass++;
      prev_p = exp_p;
    end
  endtask

  task automatic test_oneshot();
    int  exp_c;
    bit  exp_r;
    bus.glb_en = 1'b0;
    bus.presc_div = 16'd3;
    bus.cmp_val[1*W +: W] = 8'd3;
    bus.mode[1] = 1'b1;
    bus.irq_mask = 4'b0010;
    bus.start[1] = 1'b1;
    step();
    bus.glb_en = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step();
      exp_c = (j < 4) ? 0 : (j < 8) ? 1 : (j < 12) ? 2 : 3;
      exp_r = (j < 12);
      n_checks++; if (bus.count[1*W +: W] !== W'(exp_c))
        $display("FAIL os_count j=%0d got %0d exp %0d", j, bus.count[1*W +: W], exp_c); else n_pass++;
      n_checks++; if (bus.running[1] !== exp_r)
        $display("FAIL os_running j=%0d got %b exp %b", j, bus.running[1], exp_r); else n_pass++;
      n_checks++; if (bus.irq_pend[1] !== (j >= 12))
        $display("FAIL os_pend j=%0d got %b exp %b", j, bus.irq_pend[1], (j >= 12)); else n_pass++;
      n_checks++; if (bus.irq !== (j >= 13))
        $display("FAIL os_irq j=%0d got %b exp %b", j, bus.irq, (j >= 13)); else n_pass++;
    end
  endtask

  task automatic test_cmp_change();
    int exp_c;
    bus.presc_div = '0;
    bus.cmp_val[2*W +: W] = 8'd4;
    bus.mode[2] = 1'b0;
    bus.start[2] = 1'b1;
    step();
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 2) bus.cmp_val[2*W +: W] = 8'd8;
      exp_c = (j < 4) ? j : (j < 12) ? j - 4 : 0;
      n_checks++; if (bus.count[2*W +: W] !== W'(exp_c))
        $display("FAIL cmpchg_count j=%0d got %0d exp %0d", j, bus.count[2*W +: W], exp_c); else n_pass++;
    end
  endtask

  task automatic test_clr_collision();
    bus.cmp_val[3*W +: W] = 8'd3;
    bus.mode[3] = 1'b0;
    bus.irq_mask = 4'b0000;
    bus.start[3] = 1'b1;
    step();
    step();
    step();
    bus.irq_clr[3] = 1'b1;
    step();
    n_checks++; if (bus.irq_pend[3] !== 1'b1 || bus.count[3*W +: W] !== 8'd0)
      $display("FAIL clr_vs_set got pend %b cnt %0d exp 1 0", bus.irq_pend[3], bus.count[3*W +: W]); else n_pass++;
    step();
    n_checks++; if (bus.irq !== 1'b0 || bus.irq_pend[3] !== 1'b1)
      $display("FAIL masked_irq got irq %b pend %b exp 0 1", bus.irq, bus.irq_pend[3]); else n_pass++;
    bus.stop[3] = 1'b1;
    step();
    n_checks++; if (bus.running[3] !== 1'b0 || bus.count[3*W +: W] !== 8'd1)
      $display("FAIL stop_hold got run %b cnt %0d exp 0 1", bus.running[3], bus.count[3*W +: W]); else n_pass++;
    bus.irq_mask = 4'b1000;
    step();
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL unmask_irq got %b exp 1", bus.irq); else n_pass++;
    bus.irq_clr[3] = 1'b1;
    step();
    n_checks++; if (bus.irq_pend[3] !== 1'b0 || bus.irq !== 1'b1)
      $display("FAIL clr_lag got pend %b irq %b exp 0 1", bus.irq_pend[3], bus.irq); else n_pass++;
    step();
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL clr_irq_drop got %b exp 0", bus.irq); else n_pass++;
  endtask

  task automatic test_start_stop_freeze();
    int held;
    held = m_cnt[0];
    bus.start[0] = 1'b1;
    bus.stop[0]  = 1'b1;
    step();
    n_checks++; if (bus.running[0] !== 1'b0 || bus.count[0*W +: W] !== W'(held))
      $display("FAIL start_stop got run %b cnt %0d exp 0 %0d", bus.running[0], bus.count[0*W +: W], held); else n_pass++;
    bus.cmp_val[1*W +: W] = 8'd100;
    bus.mode[1] = 1'b0;
    bus.start[1] = 1'b1;
    step();
    repeat (5) step();
    n_checks++; if (bus.count[1*W +: W] !== 8'd5)
      $display("FAIL pre_freeze got %0d exp 5", bus.count[1*W +: W]); else n_pass++;
    bus.glb_en = 1'b0;
    bus.stop[2] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      n_checks++; if (bus.count[1*W +: W] !== 8'd5 || bus.running[1] !== 1'b1)
        $display("FAIL freeze j=%0d got cnt %0d run %b exp 5 1", j, bus.count[1*W +: W], bus.running[1]); else n_pass++;
    end
    n_checks++; if (bus.running[2] !== 1'b0)
      $display("FAIL stop_while_frozen got %b exp 0", bus.running[2]); else n_pass++;
    bus.glb_en = 1'b1;
    step();
    n_checks++; if (bus.count[1*W +: W] !== 8'd6)
      $display("FAIL resume got %0d exp 6", bus.count[1*W +: W]); else n_pass++;
  endtask

  task automatic test_wrap_and_rst();
    bus.cmp_val[0*W +: W] = 8'd255;
    bus.mode[0] = 1'b0;
    bus.start[0] = 1'b1;
    bus.irq_clr[0] = 1'b1;
    step();
    for (int j = 1; j <= 256; j++) begin
      step();
      if (j == 254) begin
        n_checks++; if (bus.count[0*W +: W] !== 8'd254)
          $display("FAIL wrap_254 got %0d exp 254", bus.count[0*W +: W]); else n_pass++;
      end
      if (j == 255) begin
        n_checks++; if (bus.count[0*W +: W] !== 8'd0 || bus.irq_pend[0] !== 1'b1)
          $display("FAIL wrap_255 got cnt %0d pend %b exp 0 1", bus.count[0*W +: W], bus.irq_pend[0]); else n_pass++;
      end
      if (j == 256) begin
        n_checks++; if (bus.count[0*W +: W] !== 8'd1)
          $display("FAIL wrap_256 got %0d exp 1", bus.count[0*W +: W]); else n_pass++;
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.count !== '0 || bus.running !== '0 || bus.irq_pend !== '0 || bus.irq !== 1'b0)
      $display("FAIL mid_rst got cnt %h run %b pend %b irq %b exp all 0",
               bus.count, bus.running, bus.irq_pend, bus.irq); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.glb_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) bus.presc_div = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.irq_mask = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 9) == 0) bus.cmp_val[i*W +: W] = W'($urandom_range(0, 10));
        if ($urandom_range(0, 7) == 0) begin
          bus.start[i] = 1'b1;
          bus.mode[i]  = 1'($urandom_range(0, 1));
        end
        bus.stop[i]    = ($urandom_range(0, 19) == 0);
        bus.irq_clr[i] = ($urandom_range(0, 5) == 0);
      end
      step();
      n_checks++; if (bus.count !== exp_count())
        $display("FAIL rand_count c=%0d got %h exp %h", c, bus.count, exp_count()); else n_pass++;
      n_checks++; if (bus.running !== exp_running())
        $display("FAIL rand_running c=%0d got %b exp %b", c, bus.running, exp_running()); else n_pass++;
      n_checks++; if (bus.irq_pend !== exp_pend())
        $display("FAIL rand_pend c=%0d got %b exp %b", c, bus.irq_pend, exp_pend()); else n_pass++;
      n_checks++; if (bus.irq !== m_irq)
        $display("FAIL rand_irq c=%0d got %b exp %b", c, bus.irq, m_irq); else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.glb_en    = 1'b0;
    bus.presc_div = '0;
    bus.start     = '0;
    bus.stop      = '0;
    bus.mode      = '0;
    bus.cmp_val   = '0;
    bus.irq_mask  = '0;
    bus.irq_clr   = '0;
    #2;
    test_reset();
    test_periodic();
    test_oneshot();
    test_cmp_change();
    test_clr_collision();
    test_start_stop_freeze();
    test_wrap_and_rst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
